branch_redirect_unit: RTL and testbench

- Fetch-side companion of the 2-bit branch predictor.
- Records every branch the decode stage predicts, holds it in an in-order in-flight queue, and checks it against the ALU-stage outcome.
- On a mispredict it produces the corrected PC, a one-cycle flush, and a predictor-update strobe.
- Sits between the ID/ALU pipeline registers and the PC mux.

---
 rtl/branch_redirect_unit.sv | 168 ++++++++++++++++
 tb/tb_branch_redirect_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_unit.sv
// In-order in-flight queue of predicted branches; on resolve emits predictor updates and, on a mispredict, a redirect and flush.
// Optional BRANCH_REDIRECT_PERF_EN adds saturating branch and mispredict counters.
module branch_redirect_unit #(
    parameter int PC_WIDTH = 32,
    parameter int DEPTH    = 4,
    parameter int IDX_BITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                id_branch_valid,
    input  logic [PC_WIDTH-1:0] id_pc,
    input  logic [PC_WIDTH-1:0] id_target,
    input  logic                id_predict_taken,
    input  logic                alu_branch_valid,
    input  logic                alu_branch_taken,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_addr,
    output logic                flush,
    output logic                upd_valid,
    output logic [IDX_BITS-1:0] upd_index,
    output logic                upd_taken,
    output logic                full,
    output logic                empty,
    output logic                stall_req,
    output logic                protocol_error
`ifdef BRANCH_REDIRECT_PERF_EN
    ,
    output logic [31:0]         branch_count,
    output logic [31:0]         mispredict_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] pc_mem_q  [DEPTH];
    logic [PC_WIDTH-1:0] tgt_mem_q [DEPTH];
    logic [DEPTH-1:0]    pred_mem_q;

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                redirect_valid_q, redirect_valid_d;
    logic [PC_WIDTH-1:0] redirect_addr_q, redirect_addr_d;
    logic                upd_valid_q, upd_valid_d;
    logic [IDX_BITS-1:0] upd_index_q, upd_index_d;
    logic                upd_taken_q, upd_taken_d;
    logic                perr_q, perr_d;

    logic [PC_WIDTH-1:0] rd_pc, rd_tgt;
    logic                rd_pred;
    logic                resolve, mispredict_now, push;

    // Handshake: an ID branch is accepted on a cycle with id_branch_valid=1, stall=0 and a free
    // slot (or a same-edge correct pop); stall_req tells ID to hold the branch while the queue is full.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign stall_req = id_branch_valid & full;

    always_comb begin
        rd_pc          = pc_mem_q[rd_ptr_q];
        rd_tgt         = tgt_mem_q[rd_ptr_q];
        rd_pred        = pred_mem_q[rd_ptr_q];
        resolve        = alu_branch_valid & ~stall & ~empty;
        mispredict_now = resolve & (rd_pred != alu_branch_taken);
        push           = id_branch_valid & ~stall & (~full | resolve) & ~mispredict_now;
    end

    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        redirect_valid_d = mispredict_now;
        redirect_addr_d  = redirect_addr_q;
        upd_valid_d      = resolve;
        upd_index_d      = upd_index_q;
        upd_taken_d      = upd_taken_q;
        perr_d           = perr_q | (alu_branch_valid & ~stall & empty);

        if (resolve) begin
            upd_index_d = rd_pc[IDX_BITS+1:2];
            upd_taken_d = alu_branch_taken;
        end

        // A mispredict squashes everything younger, so the queue restarts empty past the resolved slot.
        if (mispredict_now) begin
            redirect_addr_d = alu_branch_taken ? rd_tgt : (rd_pc + PC_WIDTH'(4));
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
            wr_ptr_d        = rd_ptr_q + PTR_W'(1);
            count_d         = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(resolve);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            count_d  = count_q + CNT_W'(push) - CNT_W'(resolve);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= id_pc;
            tgt_mem_q[wr_ptr_q]  <= id_target;
            pred_mem_q[wr_ptr_q] <= id_predict_taken;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_addr_q  <= '0;
            upd_valid_q      <= 1'b0;
            upd_index_q      <= '0;
            upd_taken_q      <= 1'b0;
            perr_q           <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_addr_q  <= redirect_addr_d;
            upd_valid_q      <= upd_valid_d;
            upd_index_q      <= upd_index_d;
            upd_taken_q      <= upd_taken_d;
            perr_q           <= perr_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign flush          = redirect_valid_q;
    assign redirect_addr  = redirect_addr_q;
    assign upd_valid      = upd_valid_q;
    assign upd_index      = upd_index_q;
    assign upd_taken      = upd_taken_q;
    assign protocol_error = perr_q;

`ifdef BRANCH_REDIRECT_PERF_EN
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (resolve && (branch_count_q != 32'hFFFF_FFFF))
            branch_count_d = branch_count_q + 32'd1;
        if (mispredict_now && (mispredict_count_q != 32'hFFFF_FFFF))
            mispredict_count_d = mispredict_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Bench for branch_redirect_unit: directed scenarios plus random traffic against a queue-based model.
// Also checks the counters when BRANCH_REDIRECT_PERF_EN is defined.
module tb_branch_redirect_unit;

    localparam int PW    = 32;
    localparam int DEPTH = 4;
    localparam int IB    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          id_branch_valid;
    logic [PW-1:0] id_pc;
    logic [PW-1:0] id_target;
    logic          id_predict_taken;
    logic          alu_branch_valid;
    logic          alu_branch_taken;
    logic          redirect_valid;
    logic [PW-1:0] redirect_addr;
    logic          flush;
    logic          upd_valid;
    logic [IB-1:0] upd_index;
    logic          upd_taken;
    logic          full;
    logic          empty;
    logic          stall_req;
    logic          protocol_error;
`ifdef BRANCH_REDIRECT_PERF_EN
    logic [31:0]   branch_count;
    logic [31:0]   mispredict_count;
`endif

    always #5 clk = ~clk;

    branch_redirect_unit #(.PC_WIDTH(PW), .DEPTH(DEPTH), .IDX_BITS(IB)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .id_branch_valid  (id_branch_valid),
        .id_pc            (id_pc),
        .id_target        (id_target),
        .id_predict_taken (id_predict_taken),
        .alu_branch_valid (alu_branch_valid),
        .alu_branch_taken (alu_branch_taken),
        .redirect_valid   (redirect_valid),
        .redirect_addr    (redirect_addr),
        .flush            (flush),
        .upd_valid        (upd_valid),
        .upd_index        (upd_index),
        .upd_taken        (upd_taken),
        .full             (full),
        .empty            (empty),
        .stall_req        (stall_req),
        .protocol_error   (protocol_error)
`ifdef BRANCH_REDIRECT_PERF_EN
        ,
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Model: in-flight branches in program order, each packed as {pc, target, predict_taken}.
    logic [2*PW:0] exp_q[$];
    logic          m_rv;
    logic [PW-1:0] m_addr;
    logic          m_uv;
    logic [IB-1:0] m_idx;
    logic          m_ut;
    logic          m_perr;
`ifdef BRANCH_REDIRECT_PERF_EN
    logic [31:0]   m_bc;
    logic [31:0]   m_mc;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rv   = 1'b0;
        m_addr = '0;
        m_uv   = 1'b0;
        m_idx  = '0;
        m_ut   = 1'b0;
        m_perr = 1'b0;
`ifdef BRANCH_REDIRECT_PERF_EN
        m_bc   = '0;
        m_mc   = '0;
`endif
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic [2*PW:0] e;
        logic [PW-1:0] epc;
        logic [PW-1:0] etgt;
        bit            res;
        bit            mis;
        bit            take_push;
        res  = alu_branch_valid && !stall && (exp_q.size() != 0);
        mis  = 1'b0;
        m_uv = 1'b0;
        m_rv = 1'b0;
        if (alu_branch_valid && !stall && (exp_q.size() == 0)) m_perr = 1'b1;
        if (res) begin
            e     = exp_q[0];
            epc   = e[2*PW:PW+1];
            etgt  = e[PW:1];
            mis   = (e[0] != alu_branch_taken);
            m_uv  = 1'b1;
            m_idx = epc[IB+1:2];
            m_ut  = alu_branch_taken;
`ifdef BRANCH_REDIRECT_PERF_EN
            if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
            if (mis && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
`endif
            if (mis) begin
                m_rv   = 1'b1;
                m_addr = alu_branch_taken ? etgt : epc + 32'd4;
            end
        end
        take_push = id_branch_valid && !stall && !mis && ((exp_q.size() < DEPTH) || res);
        if (mis) exp_q.delete();
        else if (res) void'(exp_q.pop_front());
        if (take_push) exp_q.push_back({id_pc, id_target, id_predict_taken});
    endtask

    task automatic check_regs();
        chk("redirect_valid", redirect_valid, m_rv);
        chk("flush", flush, m_rv);
        chk("redirect_addr", redirect_addr, m_addr);
        chk("upd_valid", upd_valid, m_uv);
        chk("upd_index", upd_index, m_idx);
        chk("upd_taken", upd_taken, m_ut);
        chk("protocol_error", protocol_error, m_perr);
        chk("empty", empty, exp_q.size() == 0);
        chk("full", full, exp_q.size() == DEPTH);
`ifdef BRANCH_REDIRECT_PERF_EN
        chk("branch_count", branch_count, m_bc);
        chk("mispredict_count", mispredict_count, m_mc);
`endif
    endtask

    task automatic cycle(input bit iv, input logic [PW-1:0] pc, input logic [PW-1:0] tgt,
                         input bit pr, input bit av, input bit at, input bit st);
        @(negedge clk);
        id_branch_valid  = iv;
        id_pc            = pc;
        id_target        = tgt;
        id_predict_taken = pr;
        alu_branch_valid = av;
        alu_branch_taken = at;
        stall            = st;
        #1;
        chk("stall_req", stall_req, iv && (exp_q.size() == DEPTH));
        model_step();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic idle();
        cycle(0, '0, '0, 0, 0, 0, 0);
    endtask

    task automatic set_idle_inputs();
        id_branch_valid  = 1'b0;
        id_pc            = '0;
        id_target        = '0;
        id_predict_taken = 1'b0;
        alu_branch_valid = 1'b0;
        alu_branch_taken = 1'b0;
        stall            = 1'b0;
    endtask

    // Called at posedge+1: drop reset between edges and expect every output cleared before the next edge.
    task automatic async_reset_mid();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redirect_addr", redirect_addr, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_upd_index", upd_index, 0);
        chk("rst_upd_taken", upd_taken, 0);
        chk("rst_protocol_error", protocol_error, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        set_idle_inputs();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        set_idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        @(negedge clk);
        reset = 1'b1;

        // Correct taken prediction.
        cycle(1, 32'h100, 32'h200, 1, 0, 0, 0);
        cycle(0, '0, '0, 0, 1, 1, 0);
        chk("t1_upd_valid", upd_valid, 1);
        chk("t1_upd_index", upd_index, 0);
        chk("t1_upd_taken", upd_taken, 1);
        chk("t1_redirect_valid", redirect_valid, 0);
        chk("t1_flush", flush, 0);
        chk("t1_empty", empty, 1);

        // Predicted taken, actually not taken: fall through to pc+4.
        cycle(1, 32'h104, 32'h80, 1, 0, 0, 0);
        cycle(0, '0, '0, 0, 1, 0, 0);
        chk("t2_redirect_valid", redirect_valid, 1);
        chk("t2_redirect_addr", redirect_addr, 32'h108);
        chk("t2_flush", flush, 1);
        chk("t2_upd_index", upd_index, 1);
        chk("t2_upd_taken", upd_taken, 0);
        idle();
        chk("t2_redirect_drop", redirect_valid, 0);
        chk("t2_addr_hold", redirect_addr, 32'h108);

        // Predicted not taken, actually taken: go to target.
        cycle(1, 32'h10, 32'h40, 0, 0, 0, 0);
        cycle(0, '0, '0, 0, 1, 1, 0);
        chk("t3_redirect_addr", redirect_addr, 32'h40);
        chk("t3_flush", flush, 1);
        idle();
        chk("t3_flush_one_cycle", flush, 0);

        // Fill, hold a fifth branch, then pop+push on the same edge.
        for (int i = 0; i < DEPTH; i++)
            cycle(1, 32'h200 + 32'(4 * i), 32'h300 + 32'(4 * i), 0, 0, 0, 0);
        chk("t4_full", full, 1);
        cycle(1, 32'h210, 32'h310, 0, 0, 0, 0);
        chk("t4_full_hold", full, 1);
        cycle(1, 32'h220, 32'h320, 0, 1, 0, 0);
        chk("t4_pop_push_full", full, 1);
        chk("t4_pop_idx", upd_index, 0);
        cycle(0, '0, '0, 0, 1, 0, 0);
        chk("t4_idx_a", upd_index, 1);
        cycle(0, '0, '0, 0, 1, 0, 0);
        chk("t4_idx_b", upd_index, 2);
        cycle(0, '0, '0, 0, 1, 0, 0);
        chk("t4_idx_c", upd_index, 3);
        cycle(0, '0, '0, 0, 1, 0, 0);
        chk("t4_idx_wrap", upd_index, 0);
        chk("t4_empty", empty, 1);

        // Oldest of three mispredicts while a new branch is offered.
        for (int i = 0; i < 3; i++)
            cycle(1, 32'h400 + 32'(4 * i), 32'h480, 1, 0, 0, 0);
        cycle(1, 32'h500, 32'h600, 1, 1, 0, 0);
        chk("t5_empty", empty, 1);
        chk("t5_redirect_addr", redirect_addr, 32'h404);
        chk("t5_redirect_valid", redirect_valid, 1);
        idle();
        chk("t5_single_pulse", redirect_valid, 0);
        chk("t5_still_empty", empty, 1);

        // pc+4 wraps around the address space.
        cycle(1, 32'hFFFF_FFFC, 32'h1000, 1, 0, 0, 0);
        cycle(0, '0, '0, 0, 1, 0, 0);
        chk("t6_wrap_addr", redirect_addr, 32'h0);

        // Stall blocks both push and resolve.
        cycle(1, 32'h700, 32'h800, 0, 0, 0, 0);
        cycle(1, 32'h704, 32'h804, 0, 1, 1, 1);
        chk("t7_stall_no_upd", upd_valid, 0);
        cycle(0, '0, '0, 0, 1, 0, 0);
        chk("t7_after_stall_empty", empty, 1);

        // Resolve on an empty queue.
        cycle(0, '0, '0, 0, 1, 1, 0);
        chk("t8_perr", protocol_error, 1);
        idle();
        idle();
        chk("t8_perr_sticky", protocol_error, 1);

        // Async reset in the middle of a cycle with live state.
        cycle(1, 32'h40, 32'h90, 1, 0, 0, 0);
        cycle(1, 32'h44, 32'h94, 1, 0, 0, 0);
        cycle(0, '0, '0, 0, 1, 0, 0);
        async_reset_mid();

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 3000; n++) begin
            bit            iv;
            bit            av;
            bit            st;
            logic [PW-1:0] rpc;
            st  = ($urandom_range(0, 7) == 0);
            iv  = $urandom_range(0, 1);
            av  = ($urandom_range(0, 2) != 0);
            if (st && exp_q.size() == 0) av = 1'b0;
            if (exp_q.size() == 0 && $urandom_range(0, 15) != 0) av = 1'b0;
            rpc = $urandom;
            cycle(iv, rpc, $urandom, $urandom_range(0, 1), av, $urandom_range(0, 1), st);
            if (n % 750 == 749) async_reset_mid();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
